// File: rtl/matrix_pkg.sv
// matrix_pkg: board geometry, cell/board types, scan states and nonzero helpers shared by the scanner.
package matrix_pkg;
   localparam int ROWS   = 8;
   localparam int COLS   = 8;
   localparam int CELL_W = 9;
   localparam int NCELLS = ROWS * COLS;
   localparam int IDX_W  = $clog2(NCELLS);
   localparam int ROW_W  = $clog2(ROWS);
   localparam int COL_W  = $clog2(COLS);
   localparam int CNT_W  = $clog2(NCELLS + 1);

   typedef logic [CELL_W-1:0] cell_t;
   typedef cell_t [ROWS-1:0][COLS-1:0] board_t;
   typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_e;

   function automatic logic [NCELLS-1:0] nz_mask(input board_t b);
      logic [NCELLS-1:0] m;
      m = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            m[r*COLS+c] = (b[r][c] != '0);
      return m;
   endfunction

   function automatic logic [CNT_W-1:0] count_nonzero(input board_t b);
      logic [NCELLS-1:0] m;
      logic [CNT_W-1:0]  n;
      m = nz_mask(b);
      n = '0;
      for (int i = 0; i < NCELLS; i++)
         n += CNT_W'(m[i]);
      return n;
   endfunction
endpackage

// File: rtl/matrix_next_cell.sv
// matrix_next_cell: lowest set bit of the emit mask at or above index 'from'.
module matrix_next_cell
   import matrix_pkg::*;
(
   input  logic [NCELLS-1:0] mask,
   input  logic [IDX_W:0]    from,
   output logic [IDX_W-1:0]  next_idx,
   output logic              has_next
);
   always_comb begin
      next_idx = '0;
      has_next = 1'b0;
      for (int i = NCELLS - 1; i >= 0; i--)
         if (mask[i] && i >= int'(from)) begin
            next_idx = IDX_W'(i);
            has_next = 1'b1;
         end
   end
endmodule

// File: rtl/matrix_scanner.sv
// matrix_scanner: snapshots the board on start and streams it row-major over valid/ready.
// Define MATRIX_SCANNER_SKIP_ZERO_EN to emit only non-zero cells.
module matrix_scanner
   import matrix_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  board_t           matrix_in,
   output logic             busy,
   output logic             cell_valid,
   input  logic             cell_ready,
   output logic [ROW_W-1:0] cell_row,
   output logic [COL_W-1:0] cell_col,
   output cell_t            cell_value,
   output logic             cell_first,
   output logic             cell_last,
   output logic             done,
   output logic [CNT_W-1:0] nonzero_cnt
);
   scan_state_e       state, state_nx;
   board_t            snap;
   logic [IDX_W-1:0]  idx, next_idx, first_idx;
   logic              first, vld, has_next, has_first, xfer;
   logic [NCELLS-1:0] snap_mask, live_mask;

`ifdef MATRIX_SCANNER_SKIP_ZERO_EN
   assign snap_mask = nz_mask(snap);
   assign live_mask = nz_mask(matrix_in);
`else
   assign snap_mask = '1;
   assign live_mask = '1;
`endif

   // next beat comes from the snapshot; the first beat is located on the live board at start
   matrix_next_cell u_next (
      .mask     (snap_mask),
      .from     ((IDX_W+1)'(idx) + (IDX_W+1)'(1)),
      .next_idx (next_idx),
      .has_next (has_next)
   );

   matrix_next_cell u_first (
      .mask     (live_mask),
      .from     ('0),
      .next_idx (first_idx),
      .has_next (has_first)
   );

   assign busy       = (state == SCAN);
   assign done       = (state == DONE);
   assign cell_valid = busy && vld;
   assign xfer       = cell_valid && cell_ready;
   assign cell_row   = ROW_W'(idx / IDX_W'(COLS));
   assign cell_col   = COL_W'(idx % IDX_W'(COLS));
   assign cell_value = snap[cell_row][cell_col];
   assign cell_first = cell_valid && first;
   assign cell_last  = cell_valid && !has_next;

   always_comb begin
      state_nx = state;
      if (state == IDLE && start) state_nx = SCAN;
      if (state == SCAN && (!vld || (cell_ready && !has_next))) state_nx = DONE;
      if (state == DONE) state_nx = IDLE;
   end

   always_ff @(posedge clk)
      if (reset) begin
         state       <= IDLE;
         snap        <= '0;
         idx         <= '0;
         first       <= 1'b0;
         vld         <= 1'b0;
         nonzero_cnt <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            snap        <= matrix_in;
            nonzero_cnt <= count_nonzero(matrix_in);
            idx         <= first_idx;
            first       <= 1'b1;
            vld         <= has_first;
         end else if (xfer) begin
            first <= 1'b0;
            if (has_next) idx <= next_idx;
            else vld <= 1'b0;
         end
      end
endmodule

// File: tb/tb_matrix_scanner.sv
// tb_matrix_scanner: random/directed stimulus checked every cycle against a queue-based scan model.
module tb_matrix_scanner;
   import matrix_pkg::*;

   logic       clk = 0, reset = 1, start = 0, cell_ready = 0;
   board_t     matrix_in = '0;
   logic       busy, cell_valid, cell_first, cell_last, done;
   logic [2:0] cell_row, cell_col;
   cell_t      cell_value;
   logic [6:0] nonzero_cnt;

   typedef struct {int row; int col; int value; bit first; bit last;} beat_t;
   beat_t q[$];
   bit    m_busy = 0, m_done = 0;
   int    m_cnt = 0;
   int    checks = 0, failures = 0;
   int    cyc = 0, t0 = 0, done_lat = -1, beats = 0, dones = 0;
   int    rmode = 0;
   bit    tog = 0;

   always #5 clk = ~clk;

   matrix_scanner dut (
      .clk(clk), .reset(reset), .start(start), .matrix_in(matrix_in),
      .busy(busy), .cell_valid(cell_valid), .cell_ready(cell_ready),
      .cell_row(cell_row), .cell_col(cell_col), .cell_value(cell_value),
      .cell_first(cell_first), .cell_last(cell_last), .done(done),
      .nonzero_cnt(nonzero_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected beat list straight from the rules: row-major, optionally zero cells dropped.
   task automatic build_scan();
      beat_t tmp[$];
      m_cnt = 0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            int v = int'(matrix_in[r][c]);
            if (v != 0) m_cnt++;
`ifdef MATRIX_SCANNER_SKIP_ZERO_EN
            if (v != 0)
`endif
               tmp.push_back('{r, c, v, 1'b0, 1'b0});
         end
      q.delete();
      for (int i = 0; i < tmp.size(); i++) begin
         beat_t b = tmp[i];
         b.first = (i == 0);
         b.last  = (i == tmp.size() - 1);
         q.push_back(b);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("valid", 32'(cell_valid), 32'(m_busy && q.size() > 0));
      if (m_busy && q.size() > 0) begin
         chk("row", 32'(cell_row), q[0].row);
         chk("col", 32'(cell_col), q[0].col);
         chk("value", 32'(cell_value), q[0].value);
         chk("first", 32'(cell_first), 32'(q[0].first));
         chk("last", 32'(cell_last), 32'(q[0].last));
      end
      if (!m_busy) chk("nonzero_cnt", 32'(nonzero_cnt), m_cnt);
      if (done) begin dones++; done_lat = cyc - t0; end
      if (cell_valid && cell_ready) beats++;
      if (reset) begin
         q.delete(); m_busy = 0; m_done = 0; m_cnt = 0;
      end else if (m_done) m_done = 0;
      else if (!m_busy) begin
         if (start) begin build_scan(); t0 = cyc; m_busy = 1; end
      end else if (q.size() == 0) begin
         m_busy = 0; m_done = 1;
      end else if (cell_ready) begin
         void'(q.pop_front());
         if (q.size() == 0) begin m_busy = 0; m_done = 1; end
      end
   end

   initial forever begin
      @(posedge clk); #2;
      tog = ~tog;
      cell_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : ($urandom_range(0, 3) != 0);
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic pulse_start();
      start = 1; step(1); start = 0;
   endtask

   task automatic wait_done(input string name, input int d0, input int maxc);
      int k = 0;
      while (dones == d0 && k < maxc) begin step(1); k++; end
      chk(name, 32'(dones != d0), 1);
      step(1);
   endtask

   task automatic rand_board(input int zero_pct);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            matrix_in[r][c] = ($urandom_range(0, 99) < zero_pct) ? '0 : cell_t'($urandom_range(1, 511));
   endtask

   int b0, d0;
   initial begin
      step(3);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_cnt", 32'(nonzero_cnt), 0);
      reset = 0;
      step(2);

      // 1: all-zero board, ready held high
      rmode = 0; matrix_in = '0; b0 = beats; d0 = dones;
      pulse_start();
      wait_done("t1_done", d0, 200);
`ifdef MATRIX_SCANNER_SKIP_ZERO_EN
      chk("t1_beats", beats - b0, 0);
      chk("t1_lat", done_lat, 2);
`else
      chk("t1_beats", beats - b0, 64);
      chk("t1_lat", done_lat, 65);
`endif
      chk("t1_cnt", 32'(nonzero_cnt), 0);

      // 2: value = idx+1, ready toggling
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            matrix_in[r][c] = cell_t'(r*8 + c + 1);
      rmode = 1; b0 = beats; d0 = dones;
      pulse_start();
      wait_done("t2_done", d0, 300);
      chk("t2_beats", beats - b0, 64);
      chk("t2_cnt", 32'(nonzero_cnt), 64);

      // 3: start re-pulsed at beats 10 and 40 and during the done cycle
      rmode = 0; rand_board(0); step(1); b0 = beats; d0 = dones;
      pulse_start();
      step(9);  pulse_start();
      step(29); pulse_start();
      step(24); pulse_start();
      step(5);
      chk("t3_beats", beats - b0, 64);
      chk("t3_dones", dones - d0, 1);
      chk("t3_idle", 32'(busy), 0);

      // 4: reset right after the 20th handshake, then a clean full scan
      rand_board(0); step(1); d0 = dones;
      pulse_start();
      step(20); reset = 1; step(1); reset = 0;
      chk("t4_valid", 32'(cell_valid), 0);
      chk("t4_busy", 32'(busy), 0);
      step(3);
      chk("t4_nodone", dones - d0, 0);
      b0 = beats;
      pulse_start();
      wait_done("t4_done", d0, 200);
      chk("t4_beats", beats - b0, 64);

      // 5: sparse board, live input wiped during the scan
      matrix_in = '0; matrix_in[0][3] = 9'd5; matrix_in[7][7] = 9'd511;
      rmode = 2; b0 = beats; d0 = dones;
      pulse_start();
      matrix_in = '0;
      wait_done("t5_done", d0, 400);
`ifdef MATRIX_SCANNER_SKIP_ZERO_EN
      chk("t5_beats", beats - b0, 2);
`else
      chk("t5_beats", beats - b0, 64);
`endif
      chk("t5_cnt", 32'(nonzero_cnt), 2);

`ifdef MATRIX_SCANNER_SKIP_ZERO_EN
      // 6: empty scan
      rmode = 0; matrix_in = '0; b0 = beats; d0 = dones;
      pulse_start();
      wait_done("t6_done", d0, 10);
      chk("t6_lat", done_lat, 2);
      chk("t6_beats", beats - b0, 0);
`endif

      // random boards with random backpressure
      rmode = 2;
      for (int i = 0; i < 4; i++) begin
         rand_board(i * 30); d0 = dones;
         pulse_start();
         wait_done("rand_done", d0, 400);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
